// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one multi-cycle memory port between fetch (IF) and data (DM) requesters
// DM has priority; a saturating starvation counter guarantees IF a grant after STARVE_MAX DM grants.
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_GNT_IF, S_GNT_DM} state_t;

  localparam logic [3:0] LP_MAX = 4'(STARVE_MAX);

  state_t              r_state, w_next;
  logic [3:0]          r_starve;
  logic                r_abort;
  logic                r_if_done, r_dm_done, r_err;
  logic                r_mem_en, r_mem_wr;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata, r_if_rdata, r_dm_rdata;
  logic                w_pick_dm;
  logic                w_viol;

  always_comb begin
    w_pick_dm = dm_req && (!if_req || (r_starve < LP_MAX));
    w_viol    = 1'b0;
    w_next    = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pick_dm)   w_next = S_GNT_DM;
        else if (if_req) w_next = S_GNT_IF;
      end
      S_GNT_IF: begin
        w_viol = !if_req;
        if (mem_ready) w_next = S_IDLE;
      end
      S_GNT_DM: begin
        w_viol = !dm_req || (dm_wr != r_mem_wr);
        if (mem_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve    <= '0;
      r_abort     <= 1'b0;
      r_err       <= 1'b0;
      r_if_done   <= 1'b0;
      r_dm_done   <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_if_done <= 1'b0;
      r_dm_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_abort <= 1'b0;
          if (w_pick_dm) begin
            r_mem_en    <= 1'b1;
            r_mem_wr    <= dm_wr;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
            if (!if_req)               r_starve <= '0;
            else if (r_starve < LP_MAX) r_starve <= r_starve + 4'd1;
          end else if (if_req) begin
            r_mem_en    <= 1'b1;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_starve    <= '0;
          end else begin
            r_starve <= '0;
          end
        end
        S_GNT_IF: begin
          if (w_viol) begin
            r_err   <= 1'b1;
            r_abort <= 1'b1;
          end
          if (mem_ready) begin
            r_mem_en <= 1'b0;
            if (!(r_abort || w_viol)) begin
              r_if_rdata <= mem_rdata;
              r_if_done  <= 1'b1;
            end
          end
        end
        S_GNT_DM: begin
          if (w_viol) begin
            r_err   <= 1'b1;
            r_abort <= 1'b1;
          end
          if (mem_ready) begin
            r_mem_en <= 1'b0;
            r_mem_wr <= 1'b0;
            // Writes complete with a done pulse but leave the last read data intact.
            if (!(r_abort || w_viol)) begin
              if (!r_mem_wr) r_dm_rdata <= mem_rdata;
              r_dm_done <= 1'b1;
            end
          end
        end
        default: r_mem_en <= 1'b0;
      endcase
    end
  end

  assign if_done   = r_if_done;
  assign if_rdata  = r_if_rdata;
  assign dm_done   = r_dm_done;
  assign dm_rdata  = r_dm_rdata;
  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != S_IDLE);
  assign err       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_wr, mem_ready;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_done, dm_done, mem_en, mem_wr, busy, err;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  int          total = 0;
  int          bad = 0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Both requesters held high with zero-wait memory: every fifth grant goes to IF.
  task automatic run_grants(input int n);
    for (int g = 0; g < n; g++) begin
      logic is_if;
      is_if = ((g % 5) == 4);
      tick();
      chk($sformatf("grant%0d_en", g), {31'd0, mem_en}, 32'd1);
      chk($sformatf("grant%0d_addr", g), {16'd0, mem_addr}, is_if ? 32'h0100 : 32'h0300);
      tick();
      if (g == n - 1) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
      chk($sformatf("done%0d", g), {30'd0, if_done, dm_done}, is_if ? 32'd2 : 32'd1);
    end
    tick();
    chk("grants_idle", {31'd0, mem_en}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0; mem_ready = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    tick(); tick();
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_done", {30'd0, if_done, dm_done}, 32'd0);
    rst = 1'b1;

    // IF only, zero wait
    if_req = 1'b1; if_addr = 16'h0010; mem_rdata = 16'hBEEF; mem_ready = 1'b1;
    tick();
    chk("t1_en", {31'd0, mem_en}, 32'd1);
    chk("t1_addr", {16'd0, mem_addr}, 32'h0010);
    chk("t1_wr", {31'd0, mem_wr}, 32'd0);
    chk("t1_busy1", {31'd0, busy}, 32'd1);
    tick();
    if_req = 1'b0;
    chk("t1_done", {31'd0, if_done}, 32'd1);
    chk("t1_rdata", {16'd0, if_rdata}, 32'hBEEF);
    chk("t1_busy2", {31'd0, busy}, 32'd0);
    chk("t1_en2", {31'd0, mem_en}, 32'd0);
    tick();
    chk("t1_pulse", {31'd0, if_done}, 32'd0);

    // DM write, 3 wait states
    mem_ready = 1'b0; mem_rdata = 16'hDEAD;
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h1234;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("t2_mem_c%0d", i), {mem_en, mem_wr, 14'd0, mem_addr ^ mem_wdata},
          {2'b11, 14'd0, 16'h0200 ^ 16'h1234});
      chk($sformatf("t2_addr_c%0d", i), {16'd0, mem_addr}, 32'h0200);
      chk($sformatf("t2_nodone_c%0d", i), {31'd0, dm_done}, 32'd0);
      if (i == 4) mem_ready = 1'b1;
    end
    tick();
    dm_req = 1'b0; dm_wr = 1'b0; mem_ready = 1'b0;
    chk("t2_done", {31'd0, dm_done}, 32'd1);
    chk("t2_rdata", {16'd0, dm_rdata}, 32'h0000);
    chk("t2_en", {31'd0, mem_en}, 32'd0);
    tick();
    chk("t2_pulse", {31'd0, dm_done}, 32'd0);

    // continuous contention
    if_addr = 16'h0100; dm_addr = 16'h0300; dm_wr = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h0000;
    if_req = 1'b1; dm_req = 1'b1;
    run_grants(10);
    chk("t3_err", {31'd0, err}, 32'd0);

    // IF read then DM read: if_rdata held
    if_req = 1'b1; if_addr = 16'h0020; mem_rdata = 16'hAAAA; mem_ready = 1'b1;
    tick(); tick();
    chk("t4_if_done", {31'd0, if_done}, 32'd1);
    chk("t4_if_rdata", {16'd0, if_rdata}, 32'hAAAA);
    if_req = 1'b0; dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0400; mem_rdata = 16'h5555;
    tick();
    chk("t4_dm_addr", {16'd0, mem_addr}, 32'h0400);
    tick();
    dm_req = 1'b0;
    chk("t4_dm_done", {31'd0, dm_done}, 32'd1);
    chk("t4_dm_rdata", {16'd0, dm_rdata}, 32'h5555);
    chk("t4_if_hold", {16'd0, if_rdata}, 32'hAAAA);
    tick();

    // granted DM drops its request mid-access
    mem_ready = 1'b0; dm_req = 1'b1; dm_addr = 16'h0500; mem_rdata = 16'h7777;
    tick();
    chk("t5_err0", {31'd0, err}, 32'd0);
    dm_req = 1'b0;
    tick();
    chk("t5_err1", {31'd0, err}, 32'd1);
    chk("t5_wait_en", {31'd0, mem_en}, 32'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("t5_no_done", {31'd0, dm_done}, 32'd0);
    chk("t5_en", {31'd0, mem_en}, 32'd0);
    chk("t5_rdata", {16'd0, dm_rdata}, 32'h5555);
    tick();
    chk("t5_no_done2", {31'd0, dm_done}, 32'd0);
    chk("t5_sticky", {31'd0, err}, 32'd1);

    // reset during IF wait states
    if_req = 1'b1; if_addr = 16'h0600;
    tick();
    chk("t6_busy", {31'd0, busy}, 32'd1);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("t6_en", {31'd0, mem_en}, 32'd0);
    chk("t6_busy0", {31'd0, busy}, 32'd0);
    chk("t6_done", {31'd0, if_done}, 32'd0);
    chk("t6_err", {31'd0, err}, 32'd0);
    if_addr = 16'h0100; dm_addr = 16'h0300; mem_ready = 1'b1; mem_rdata = 16'h0000;
    if_req = 1'b1; dm_req = 1'b1;
    tick();
    rst = 1'b1;
    run_grants(5);
    chk("t6_no_err", {31'd0, err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
